// File: rtl/mole_sequencer.sv
// mole_sequencer: pre-game countdown, one-mole-at-a-time sequencing and hit/miss scoring for the game FSM.
// Optional MOLE_SPEEDUP_EN: each hit shortens the mole lifetime by MOLE_MS/16, floored at MOLE_MS/4.
module mole_sequencer #(
  parameter int          MS_CYCLES    = 50000,
  parameter int          COUNTDOWN_MS = 3000,
  parameter int          MOLE_MS      = 1000,
  parameter int          NUM_HOLES    = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 wait_flag,
  input  logic                 play_flag,
  input  logic                 new_mole,
  input  logic [NUM_HOLES-1:0] hit,
  output logic                 countdown_complete,
  output logic [3:0]           countdown_sec,
  output logic                 mole_complete,
  output logic [NUM_HOLES-1:0] mole_onehot,
  output logic [7:0]           hit_count,
  output logic [7:0]           miss_count,
  output logic [12:0]          reaction_ms
);
  localparam int HB       = $clog2(NUM_HOLES);
  localparam int PW       = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
  localparam int SEC_INIT = (COUNTDOWN_MS + 999) / 1000;
  // Remaining ms is tracked as (sec-1)*1000 + sub, so sub runs 1..1000 within each displayed second.
  localparam int SUB_INIT = COUNTDOWN_MS - (SEC_INIT - 1) * 1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNTDOWN,
    S_ARM,
    S_MOLE_UP,
    S_DONE
  } state_t;

  state_t               state_reg;
  logic [PW-1:0]        presc_reg;
  logic [15:0]          ms_cnt_reg;
  logic [9:0]           sub_reg;
  logic [15:0]          lfsr_reg;
  logic [NUM_HOLES-1:0] hit_q_reg;
  logic                 wait_q_reg;
  logic [HB-1:0]        prev_hole_reg;

  logic                 tick;
  logic                 lfsr_fb;
  logic                 lit_hit;
  logic                 go_idle;
  logic [HB-1:0]        rand_hole;
  logic [HB-1:0]        arm_hole;
  logic [NUM_HOLES-1:0] lit_rise;
  logic [15:0]          life_ms;

`ifdef MOLE_SPEEDUP_EN
  localparam int STEP_MS  = MOLE_MS / 16;
  localparam int FLOOR_MS = MOLE_MS / 4;
  logic [15:0] life_reg;
  assign life_ms = life_reg;
`else
  assign life_ms = 16'(MOLE_MS);
`endif

  assign tick    = (presc_reg == PW'(MS_CYCLES - 1));
  assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

  // Never light the same hole twice in a row.
  assign rand_hole = lfsr_reg[HB-1:0];
  assign arm_hole  = (rand_hole == prev_hole_reg) ? rand_hole + HB'(1) : rand_hole;

  for (genvar gi = 0; gi < NUM_HOLES; gi++) begin : g_rise
    assign lit_rise[gi] = hit[gi] & ~hit_q_reg[gi] & mole_onehot[gi];
  end
  assign lit_hit = |lit_rise;

  assign go_idle = clear
                 | ((state_reg == S_COUNTDOWN) & ~wait_flag & ~play_flag)
                 | (((state_reg == S_ARM) | (state_reg == S_MOLE_UP) | (state_reg == S_DONE)) & ~play_flag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= S_IDLE;
      presc_reg          <= '0;
      ms_cnt_reg         <= '0;
      sub_reg            <= '0;
      lfsr_reg           <= LFSR_SEED;
      hit_q_reg          <= '0;
      wait_q_reg         <= 1'b0;
      prev_hole_reg      <= '0;
      countdown_complete <= 1'b0;
      countdown_sec      <= '0;
      mole_complete      <= 1'b0;
      mole_onehot        <= '0;
      hit_count          <= '0;
      miss_count         <= '0;
      reaction_ms        <= '0;
`ifdef MOLE_SPEEDUP_EN
      life_reg           <= 16'(MOLE_MS);
`endif
    end else begin
      lfsr_reg      <= {lfsr_reg[14:0], lfsr_fb};
      hit_q_reg     <= hit;
      wait_q_reg    <= wait_flag;
      presc_reg     <= tick ? '0 : presc_reg + PW'(1);
      mole_complete <= 1'b0;

      if (go_idle) begin
        state_reg          <= S_IDLE;
        presc_reg          <= '0;
        countdown_complete <= 1'b0;
        countdown_sec      <= '0;
        mole_onehot        <= '0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (wait_flag && !wait_q_reg) begin
              state_reg     <= S_COUNTDOWN;
              presc_reg     <= '0;
              ms_cnt_reg    <= 16'(COUNTDOWN_MS);
              sub_reg       <= 10'(SUB_INIT);
              countdown_sec <= 4'(SEC_INIT);
              hit_count     <= '0;
              miss_count    <= '0;
              reaction_ms   <= '0;
`ifdef MOLE_SPEEDUP_EN
              life_reg      <= 16'(MOLE_MS);
`endif
            end
          end
          S_COUNTDOWN: begin
            if (play_flag) begin
              state_reg          <= S_ARM;
              presc_reg          <= '0;
              countdown_complete <= 1'b0;
              countdown_sec      <= '0;
            end else if (tick && ms_cnt_reg != 16'd0) begin
              ms_cnt_reg <= ms_cnt_reg - 16'd1;
              if (ms_cnt_reg == 16'd1) begin
                countdown_complete <= 1'b1;
                countdown_sec      <= '0;
              end else if (sub_reg == 10'd1) begin
                countdown_sec <= countdown_sec - 4'd1;
                sub_reg       <= 10'd1000;
              end else begin
                sub_reg <= sub_reg - 10'd1;
              end
            end
          end
          S_ARM: begin
            state_reg     <= S_MOLE_UP;
            presc_reg     <= '0;
            ms_cnt_reg    <= '0;
            prev_hole_reg <= arm_hole;
            mole_onehot   <= NUM_HOLES'(1) << arm_hole;
          end
          S_MOLE_UP: begin
            // A hit landing on the timeout cycle is scored as a hit.
            if (lit_hit) begin
              state_reg     <= S_DONE;
              presc_reg     <= '0;
              mole_onehot   <= '0;
              mole_complete <= 1'b1;
              hit_count     <= (hit_count == 8'hFF) ? hit_count : hit_count + 8'd1;
              reaction_ms   <= (ms_cnt_reg > 16'd8191) ? 13'h1FFF : ms_cnt_reg[12:0];
`ifdef MOLE_SPEEDUP_EN
              life_reg      <= (life_reg >= 16'(FLOOR_MS + STEP_MS)) ? life_reg - 16'(STEP_MS)
                                                                     : 16'(FLOOR_MS);
`endif
            end else if (tick) begin
              if (ms_cnt_reg >= life_ms - 16'd1) begin
                state_reg     <= S_DONE;
                presc_reg     <= '0;
                mole_onehot   <= '0;
                mole_complete <= 1'b1;
                miss_count    <= (miss_count == 8'hFF) ? miss_count : miss_count + 8'd1;
              end else begin
                ms_cnt_reg <= ms_cnt_reg + 16'd1;
              end
            end
          end
          S_DONE: begin
            if (new_mole) begin
              state_reg <= S_ARM;
              presc_reg <= '0;
            end
          end
          default: begin
            state_reg <= S_IDLE;
            presc_reg <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mole_sequencer.sv
// tb_mole_sequencer: randomized self-checking bench for mole_sequencer with a ms-level scoring model.
module tb_mole_sequencer;
  localparam int MS   = 4;
  localparam int CDMS = 3;
  localparam int MOLE = 5;
  localparam int NH   = 8;
  localparam int LIT_CYCLES = MOLE * MS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          wait_flag = 1'b0;
  logic          play_flag = 1'b0;
  logic          new_mole = 1'b0;
  logic [NH-1:0] hit = '0;
  logic          countdown_complete;
  logic [3:0]    countdown_sec;
  logic          mole_complete;
  logic [NH-1:0] mole_onehot;
  logic [7:0]    hit_count;
  logic [7:0]    miss_count;
  logic [12:0]   reaction_ms;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoring model: what the player should see on the counters.
  int            m_hits   = 0;
  int            m_misses = 0;
  int            m_react  = 0;
  logic [NH-1:0] last_lit = '0;

  always #5 clk = ~clk;

  mole_sequencer #(
    .MS_CYCLES(MS), .COUNTDOWN_MS(CDMS), .MOLE_MS(MOLE), .NUM_HOLES(NH), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wait_flag(wait_flag), .play_flag(play_flag),
    .new_mole(new_mole), .hit(hit), .countdown_complete(countdown_complete),
    .countdown_sec(countdown_sec), .mole_complete(mole_complete), .mole_onehot(mole_onehot),
    .hit_count(hit_count), .miss_count(miss_count), .reaction_ms(reaction_ms)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game(input string tag);
    int n;
    play_flag = 1'b0; wait_flag = 1'b0; hit = '0;
    cyc(); cyc();
    wait_flag = 1'b1;
    n = 0;
    while (!countdown_complete && n < 40) begin cyc(); n++; end
    n_tests++;
    if (countdown_complete !== 1'b1) begin
      n_fail++; $display("FAIL %s countdown: complete=%b after %0d cycles, required 1", tag, countdown_complete, n);
    end
    m_hits = 0; m_misses = 0; m_react = 0;
    play_flag = 1'b1;
    n = 0;
    while (mole_onehot == '0 && n < 5) begin cyc(); n++; end
    n_tests++;
    if (mole_onehot == '0) begin
      n_fail++; $display("FAIL %s first_mole: led=%b, required a lit hole", tag, mole_onehot);
    end
    n_tests++;
    if ({hit_count, miss_count, reaction_ms} !== '0) begin
      n_fail++; $display("FAIL %s game_start_clear: hits=%0d misses=%0d react=%0d, required 0/0/0",
                         tag, hit_count, miss_count, reaction_ms);
    end
    $display("[TB] %s: game started, lit=%b", tag, mole_onehot);
  endtask

  task automatic next_mole(input string tag);
    int n;
    new_mole = 1'b1;
    cyc();
    new_mole = 1'b0;
    n_tests++;
    if (mole_complete !== 1'b0) begin
      n_fail++; $display("FAIL %s pulse_width: mole_complete=%b on second cycle, required 0", tag, mole_complete);
    end
    n = 0;
    while (mole_onehot == '0 && n < 5) begin cyc(); n++; end
    n_tests++;
    if (mole_onehot == '0) begin
      n_fail++; $display("FAIL %s next_mole: led=%b, required a lit hole", tag, mole_onehot);
    end
  endtask

  // Runs one lit mole. press_k: lit-cycle index at which the button goes down (<0: never).
  task automatic play_mole(input int press_k, input bit right, input bit release_after, input string tag);
    logic [NH-1:0] lit, mask;
    int  n, shift, lo, hi;
    bit  done, led_bad, exp_hit;
    lit = mole_onehot;
    n_tests++;
    if (!$onehot(lit)) begin
      n_fail++; $display("FAIL %s onehot: led=%b, required exactly one bit", tag, lit);
    end
    if (last_lit != '0) begin
      n_tests++;
      if (lit == last_lit) begin
        n_fail++; $display("FAIL %s repeat_hole: led=%b, required different from %b", tag, lit, last_lit);
      end
    end
    last_lit = lit;
    shift = $urandom_range(1, NH - 1);
    mask  = right ? lit : ((lit << shift) | (lit >> (NH - shift)));
    exp_hit = right && (press_k >= 0) && (press_k < LIT_CYCLES);
    n = 0; done = 1'b0; led_bad = 1'b0;
    while (!done && n < 40) begin
      if (n == press_k) hit = mask;
      cyc();
      n++;
      if (mole_complete) done = 1'b1;
      else if (mole_onehot !== lit) led_bad = 1'b1;
    end
    lo = exp_hit ? press_k + 1 : LIT_CYCLES - 1;
    hi = exp_hit ? press_k + 2 : LIT_CYCLES + 1;
    n_tests++;
    if (!done || n < lo || n > hi) begin
      n_fail++; $display("FAIL %s complete_time: done=%b at cycle %0d, required pulse in %0d..%0d", tag, done, n, lo, hi);
    end
    n_tests++;
    if (led_bad) begin
      n_fail++; $display("FAIL %s led_stable: led changed before mole ended, required %b", tag, lit);
    end
    n_tests++;
    if (mole_onehot !== '0) begin
      n_fail++; $display("FAIL %s led_off: led=%b after mole end, required 0", tag, mole_onehot);
    end
    if (exp_hit) begin
      m_hits  = (m_hits < 255) ? m_hits + 1 : 255;
      m_react = press_k / MS;
    end else begin
      m_misses = (m_misses < 255) ? m_misses + 1 : 255;
    end
    n_tests++;
    if (hit_count !== 8'(m_hits) || miss_count !== 8'(m_misses) || reaction_ms !== 13'(m_react)) begin
      n_fail++; $display("FAIL %s score: hits=%0d misses=%0d react=%0d, required %0d/%0d/%0d",
                         tag, hit_count, miss_count, reaction_ms, m_hits, m_misses, m_react);
    end
    $display("[TB] %s: lit=%b press=%0d right=%0d end=%0d hits=%0d misses=%0d react=%0d",
             tag, lit, press_k, right, n, hit_count, miss_count, reaction_ms);
    if (release_after) hit = '0;
  endtask

  task automatic test_reset();
    cyc(); cyc();
    n_tests++;
    if ({countdown_complete, countdown_sec, mole_complete, mole_onehot, hit_count, miss_count, reaction_ms} !== '0) begin
      n_fail++; $display("FAIL reset outputs: cc=%b sec=%0d mc=%b led=%b hits=%0d misses=%0d react=%0d, required all 0",
                         countdown_complete, countdown_sec, mole_complete, mole_onehot, hit_count, miss_count, reaction_ms);
    end
    rst_n = 1'b1;
    cyc();
    n_tests++;
    if ({countdown_complete, mole_onehot, mole_complete} !== '0) begin
      n_fail++; $display("FAIL reset idle: cc=%b led=%b mc=%b, required 0", countdown_complete, mole_onehot, mole_complete);
    end
    $display("[TB] reset: done");
  endtask

  task automatic test_countdown();
    int n;
    wait_flag = 1'b1;
    cyc();
    n = 1;
    n_tests++;
    if (countdown_sec !== 4'd1 || countdown_complete !== 1'b0) begin
      n_fail++; $display("FAIL countdown start: sec=%0d cc=%b, required 1/0", countdown_sec, countdown_complete);
    end
    while (!countdown_complete && n < 40) begin cyc(); n++; end
    n_tests++;
    if (!countdown_complete || n < 11 || n > 13) begin
      n_fail++; $display("FAIL countdown length: cc=%b after %0d cycles, required 1 after 11..13", countdown_complete, n);
    end
    n_tests++;
    if (countdown_sec !== 4'd0) begin
      n_fail++; $display("FAIL countdown sec_end: sec=%0d, required 0", countdown_sec);
    end
    repeat (5) cyc();
    n_tests++;
    if (countdown_complete !== 1'b1) begin
      n_fail++; $display("FAIL countdown held: cc=%b, required 1", countdown_complete);
    end
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    n_tests++;
    if (countdown_complete !== 1'b0) begin
      n_fail++; $display("FAIL countdown clear: cc=%b, required 0", countdown_complete);
    end
    repeat (3) cyc();
    n_tests++;
    if (countdown_complete !== 1'b0 || countdown_sec !== 4'd0) begin
      n_fail++; $display("FAIL countdown stay_idle: cc=%b sec=%0d, required 0/0", countdown_complete, countdown_sec);
    end
    wait_flag = 1'b0;
    $display("[TB] countdown: complete after %0d cycles", n);
  endtask

  task automatic test_timeout();
    start_game("timeout");
    play_mole(-1, 1'b1, 1'b1, "timeout");
  endtask

  task automatic test_hit();
    next_mole("hit");
    play_mole(2 * MS, 1'b1, 1'b1, "hit_2ms");
    next_mole("hit_after");
  endtask

  task automatic test_wrong_and_held();
    play_mole(3, 1'b0, 1'b1, "wrong_hole");
    next_mole("held");
    play_mole(2, 1'b1, 1'b0, "held_press");
    hit = '1;
    next_mole("held_next");
    play_mole(-1, 1'b1, 1'b1, "held_across");
  endtask

  task automatic test_hit_on_timeout();
    next_mole("edge");
    play_mole(LIT_CYCLES - 1, 1'b1, 1'b1, "hit_on_timeout");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      next_mole("random");
      play_mole(int'($urandom_range(0, LIT_CYCLES + 4)), ($urandom_range(0, 3) != 0), 1'b1, "random");
    end
  endtask

  task automatic test_clear_reset();
    next_mole("clear");
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    n_tests++;
    if (mole_onehot !== '0 || countdown_complete !== 1'b0) begin
      n_fail++; $display("FAIL clear led: led=%b cc=%b, required 0/0", mole_onehot, countdown_complete);
    end
    n_tests++;
    if (hit_count !== 8'(m_hits) || miss_count !== 8'(m_misses) || reaction_ms !== 13'(m_react)) begin
      n_fail++; $display("FAIL clear retain: hits=%0d misses=%0d react=%0d, required %0d/%0d/%0d",
                         hit_count, miss_count, reaction_ms, m_hits, m_misses, m_react);
    end
    start_game("play_drop");
    play_flag = 1'b0;
    cyc();
    n_tests++;
    if (mole_onehot !== '0) begin
      n_fail++; $display("FAIL play_drop led: led=%b, required 0", mole_onehot);
    end
    start_game("pre_reset");
    play_mole(5, 1'b1, 1'b1, "pre_reset");
    next_mole("pre_reset");
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({countdown_complete, countdown_sec, mole_complete, mole_onehot, hit_count, miss_count, reaction_ms} !== '0) begin
      n_fail++; $display("FAIL async_reset: led=%b hits=%0d misses=%0d react=%0d, required all 0",
                         mole_onehot, hit_count, miss_count, reaction_ms);
    end
    m_hits = 0; m_misses = 0; m_react = 0; last_lit = '0;
    play_flag = 1'b0; wait_flag = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    $display("[TB] clear_reset: done");
  endtask

  task automatic test_saturation();
    start_game("saturation");
    for (int i = 0; i < 300; i++) begin
      play_mole(0, 1'b1, 1'b1, "sat");
      next_mole("sat");
    end
    n_tests++;
    if (hit_count !== 8'd255) begin
      n_fail++; $display("FAIL saturation: hits=%0d, required 255", hit_count);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_countdown();
    test_timeout();
    test_hit();
    test_wrong_and_held();
    test_hit_on_timeout();
    test_random();
    test_clear_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
